tt_ovi_completion: RTL and testbench

- In-order completion tracker directly downstream of the vector issue FIFO, alongside the Ocelot VPU.
- Records the sb_id of every instruction the FIFO hands to the VPU.
- Pairs each VPU retire pulse with the oldest outstanding sb_id.
- Drives the OVI completed interface and the issue-credit return to the scalar core, one registered cycle after retire.

---
 rtl/tt_ovi_completion.sv | 99 +++++++++
 tb/tb_tt_ovi_completion.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tt_ovi_completion.sv
// tt_ovi_completion
//   In-order completion tracker sitting behind the vector issue FIFO. Each
//   instruction issued to the VPU has its sb_id queued. Each VPU retire pulse
//   is paired with the oldest queued sb_id. The match is reported on the OVI
//   completed interface, together with an issue-credit return, one
//   registered cycle after the retire.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   issue_fire/sb_id      instruction handed to the VPU this cycle
//   issue_ready           tracker has room (= !full, from registered count)
//   vpu_retire_*          retire pulse plus its exception/saturation/illegal flags
//   completed_*           registered completion pulse, sb_id and flags
//   issue_credit          credit return, same timing as completed_valid
//   outstanding           current occupancy
//   err_underflow         sticky: a retire arrived while nothing was outstanding
module tt_ovi_completion #(
  parameter int DEPTH = 8,
  parameter int SB_W  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_fire,
  input  logic [SB_W-1:0]            issue_sb_id,
  output logic                       issue_ready,
  input  logic                       vpu_retire_valid,
  input  logic [4:0]                 vpu_retire_fflags,
  input  logic                       vpu_retire_vxsat,
  input  logic                       vpu_retire_illegal,
  output logic                       completed_valid,
  output logic [SB_W-1:0]            completed_sb_id,
  output logic [4:0]                 completed_fflags,
  output logic                       completed_vxsat,
  output logic                       completed_illegal,
  output logic                       issue_credit,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [SB_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, push, pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Both decisions use the pre-update count. A retire that arrives together
  // with the first push into an empty tracker is therefore not matched.
  assign push  = issue_fire && !full;
  assign pop   = vpu_retire_valid && !empty;

  assign issue_ready = !full;
  assign outstanding = count;

  // The payload storage needs no reset. The pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= issue_sb_id;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      completed_valid   <= 1'b0;
      issue_credit      <= 1'b0;
      completed_sb_id   <= '0;
      completed_fflags  <= '0;
      completed_vxsat   <= 1'b0;
      completed_illegal <= 1'b0;
      err_underflow     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      completed_valid <= pop;
      issue_credit    <= pop;
      // On idle cycles the payload keeps its last value. Only the valid/credit pulse drops.
      if (pop) begin
        completed_sb_id   <= mem[rd_ptr];
        completed_fflags  <= vpu_retire_fflags;
        completed_vxsat   <= vpu_retire_vxsat;
        completed_illegal <= vpu_retire_illegal;
      end

      if (vpu_retire_valid && empty) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tt_ovi_completion.sv
module tb_tt_ovi_completion;

  localparam int DEPTH = 8;
  localparam int SB_W  = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_fire;
  logic [SB_W-1:0] issue_sb_id;
  logic            issue_ready;
  logic            vpu_retire_valid;
  logic [4:0]      vpu_retire_fflags;
  logic            vpu_retire_vxsat;
  logic            vpu_retire_illegal;
  logic            completed_valid;
  logic [SB_W-1:0] completed_sb_id;
  logic [4:0]      completed_fflags;
  logic            completed_vxsat;
  logic            completed_illegal;
  logic            issue_credit;
  logic [3:0]      outstanding;
  logic            err_underflow;

  int checks = 0;
  int failures = 0;

  tt_ovi_completion #(.DEPTH(DEPTH), .SB_W(SB_W)) dut (
    .clk(clk), .reset(reset),
    .issue_fire(issue_fire), .issue_sb_id(issue_sb_id), .issue_ready(issue_ready),
    .vpu_retire_valid(vpu_retire_valid), .vpu_retire_fflags(vpu_retire_fflags),
    .vpu_retire_vxsat(vpu_retire_vxsat), .vpu_retire_illegal(vpu_retire_illegal),
    .completed_valid(completed_valid), .completed_sb_id(completed_sb_id),
    .completed_fflags(completed_fflags), .completed_vxsat(completed_vxsat),
    .completed_illegal(completed_illegal), .issue_credit(issue_credit),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, step past the next rising edge, and return 1ns after it.
  task automatic cyc(input logic iv, input logic [SB_W-1:0] sb, input logic rv,
                     input logic [4:0] ff = '0, input logic vx = 1'b0, input logic il = 1'b0);
    issue_fire = iv; issue_sb_id = sb;
    vpu_retire_valid = rv; vpu_retire_fflags = ff;
    vpu_retire_vxsat = vx; vpu_retire_illegal = il;
    @(posedge clk);
    #1;
    issue_fire = 1'b0; vpu_retire_valid = 1'b0;
  endtask

  // Check one completion (sb_id and pulse/credit) right after its edge.
  task automatic chk_comp(input string tag, input logic [SB_W-1:0] sb);
    chk({tag, "_valid"},  {31'd0, completed_valid}, 32'd1);
    chk({tag, "_credit"}, {31'd0, issue_credit},    32'd1);
    chk({tag, "_sb"},     {27'd0, completed_sb_id}, {27'd0, sb});
  endtask

  // The bench never pushes into a full tracker.
  always @(posedge clk)
    if (!reset && issue_fire && !issue_ready) chk("no_push_when_full", 32'd1, 32'd0);

  initial begin
    reset = 1'b1;
    issue_fire = 0; issue_sb_id = '0; vpu_retire_valid = 0;
    vpu_retire_fflags = '0; vpu_retire_vxsat = 0; vpu_retire_illegal = 0;
    #22;
    chk("rst_valid",   {31'd0, completed_valid}, 32'd0);
    chk("rst_credit",  {31'd0, issue_credit},    32'd0);
    chk("rst_sb",      {27'd0, completed_sb_id}, 32'd0);
    chk("rst_ready",   {31'd0, issue_ready},     32'd1);
    chk("rst_out",     {28'd0, outstanding},     32'd0);
    chk("rst_err",     {31'd0, err_underflow},   32'd0);
    reset = 1'b0;

    // Basic in-order issue then retire.
    cyc(1, 5'd3, 0); cyc(1, 5'd7, 0); cyc(1, 5'd12, 0);
    chk("s1_out3", {28'd0, outstanding}, 32'd3);
    chk("s1_nocomp", {31'd0, completed_valid}, 32'd0);
    cyc(0, 0, 1); chk_comp("s1_c0", 5'd3);
    cyc(0, 0, 1); chk_comp("s1_c1", 5'd7);
    cyc(0, 0, 1); chk_comp("s1_c2", 5'd12);
    cyc(0, 0, 0);
    chk("s1_pulse_end", {31'd0, completed_valid}, 32'd0);
    chk("s1_credit_end", {31'd0, issue_credit}, 32'd0);
    chk("s1_sb_hold", {27'd0, completed_sb_id}, 32'd12);
    chk("s1_out0", {28'd0, outstanding}, 32'd0);

    // Fill to full, one retire, then a push that wraps into slot 0.
    for (int i = 0; i < DEPTH; i++) cyc(1, SB_W'(i), 0);
    chk("s2_full_out", {28'd0, outstanding}, 32'd8);
    chk("s2_full_ready", {31'd0, issue_ready}, 32'd0);
    cyc(0, 0, 1); chk_comp("s2_c0", 5'd0);
    chk("s2_ready_after", {31'd0, issue_ready}, 32'd1);
    cyc(1, 5'd8, 0);
    chk("s2_refull", {28'd0, outstanding}, 32'd8);
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(0, 0, 1);
      chk_comp($sformatf("s2_c%0d", i), SB_W'(i));
    end
    chk("s2_out0", {28'd0, outstanding}, 32'd0);

    // Simultaneous push and pop keep the occupancy unchanged.
    cyc(1, 5'd30, 0); cyc(1, 5'd31, 0);
    cyc(1, 5'd20, 1); chk_comp("s3_c0", 5'd30);
    chk("s3_out2", {28'd0, outstanding}, 32'd2);
    cyc(0, 0, 1); chk_comp("s3_c1", 5'd31);
    cyc(0, 0, 1); chk_comp("s3_c2", 5'd20);

    // Flag pass-through.
    cyc(1, 5'd5, 0); cyc(1, 5'd6, 0);
    cyc(0, 0, 1, 5'b10001, 1'b1, 1'b0); chk_comp("s4_c0", 5'd5);
    chk("s4_ff", {27'd0, completed_fflags}, 32'h11);
    chk("s4_vx", {31'd0, completed_vxsat}, 32'd1);
    chk("s4_il", {31'd0, completed_illegal}, 32'd0);
    cyc(0, 0, 1, 5'b00110, 1'b0, 1'b1); chk_comp("s4_c1", 5'd6);
    chk("s4_ff2", {27'd0, completed_fflags}, 32'h06);
    chk("s4_vx2", {31'd0, completed_vxsat}, 32'd0);
    chk("s4_il2", {31'd0, completed_illegal}, 32'd1);
    cyc(0, 0, 0);
    chk("s4_ff_hold", {27'd0, completed_fflags}, 32'h06);

    // A retire into an empty tracker is not matched with a same-cycle issue.
    chk("s5_err_pre", {31'd0, err_underflow}, 32'd0);
    cyc(1, 5'd9, 1);
    chk("s5_nocomp", {31'd0, completed_valid}, 32'd0);
    chk("s5_nocredit", {31'd0, issue_credit}, 32'd0);
    chk("s5_err", {31'd0, err_underflow}, 32'd1);
    chk("s5_out1", {28'd0, outstanding}, 32'd1);
    cyc(0, 0, 1); chk_comp("s5_c0", 5'd9);
    chk("s5_err_sticky", {31'd0, err_underflow}, 32'd1);

    // Asynchronous reset in mid-cycle while a completion is pending.
    cyc(1, 5'd1, 0); cyc(1, 5'd2, 0); cyc(1, 5'd3, 0); cyc(1, 5'd4, 0);
    cyc(0, 0, 1);
    chk("s6_out_pre", {28'd0, outstanding}, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("s6_valid", {31'd0, completed_valid}, 32'd0);
    chk("s6_credit", {31'd0, issue_credit}, 32'd0);
    chk("s6_sb", {27'd0, completed_sb_id}, 32'd0);
    chk("s6_ready", {31'd0, issue_ready}, 32'd1);
    chk("s6_out", {28'd0, outstanding}, 32'd0);
    chk("s6_err", {31'd0, err_underflow}, 32'd0);
    #1 reset = 1'b0;
    cyc(1, 5'd17, 0); cyc(1, 5'd18, 0);
    cyc(0, 0, 1); chk_comp("s6_c0", 5'd17);
    cyc(0, 0, 1); chk_comp("s6_c1", 5'd18);
    chk("s6_out_end", {28'd0, outstanding}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
